// File: rtl/shift_pkg.sv
// Shared types and constants for the operand-2 shift stage, plus the decoder that
// folds (ShByReg, ShType, Shamt) into a barrel-core request and a special-case code.
package shift_pkg;

  localparam int SH_DATA_W = 32;
  localparam int SH_AMT_W  = 8;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  typedef enum logic [2:0] {
    SP_CORE,       // barrel core result by amt5 (1..31)
    SP_PASS,       // Src unchanged, C = CarryIn
    SP_ZERO_CLSB,  // 0, C = Src[0]
    SP_ZERO_CMSB,  // 0, C = Src[31]
    SP_ZERO_C0,    // 0, C = 0
    SP_SIGN,       // all sign bits, C = Src[31]
    SP_RRX,        // {CarryIn, Src[31:1]}, C = Src[0]
    SP_ROR32       // Src, C = Src[31]
  } sh_special_e;

  typedef struct packed {
    sh_type_e    kind;
    logic [4:0]  amt5;
    sh_special_e code;
  } sh_norm_t;

  typedef struct packed {
    logic [SH_DATA_W-1:0] data;
    logic                 carry;
  } sh_result_t;

  function automatic sh_norm_t shift_normalise(input logic                by_reg,
                                               input sh_type_e            ty,
                                               input logic [SH_AMT_W-1:0] shamt);
    sh_norm_t n;
    n.kind = ty;
    n.amt5 = shamt[4:0];
    n.code = SP_CORE;
    if (!by_reg) begin
      // An imm5 of zero encodes a distinct operation for every type but LSL.
      if (shamt[4:0] == 5'd0) begin
        unique case (ty)
          SH_LSL: n.code = SP_PASS;
          SH_LSR: n.code = SP_ZERO_CMSB;
          SH_ASR: n.code = SP_SIGN;
          SH_ROR: n.code = SP_RRX;
        endcase
      end
    end else if (shamt == 8'd0) begin
      n.code = SP_PASS;
    end else begin
      unique case (ty)
        SH_LSL: if (shamt == 8'd32) n.code = SP_ZERO_CLSB;
                else if (shamt > 8'd32) n.code = SP_ZERO_C0;
        SH_LSR: if (shamt == 8'd32) n.code = SP_ZERO_CMSB;
                else if (shamt > 8'd32) n.code = SP_ZERO_C0;
        SH_ASR: if (shamt >= 8'd32) n.code = SP_SIGN;
        SH_ROR: if (shamt[4:0] == 5'd0) n.code = SP_ROR32;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 5-stage logarithmic barrel shifter (LSL/LSR/ASR/ROR by 0..31) with
// carry-out = last bit shifted out. LSL is done as a right shift of the bit-reversed operand.
module shift_core
  import shift_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [4:0]  amt5,
  input  logic [31:0] src,
  output logic [31:0] result,
  output logic        carry
);

  sh_type_e    ty;
  logic [31:0] src_rev;
  logic [31:0] res_rev;
  logic [31:0] fill;
  logic [32:0] ext;
  logic [64:0] wide;

  assign ty = sh_type_e'(kind);

  // ext = {data, guard}; shifting the guard along with the data leaves the last
  // bit shifted out in ext[0] after all stages.
  always_comb begin
    // NOTE: blocking assignments here - each stage must see the previous stage's value
    // within the same evaluation; registered state elsewhere uses non-blocking.
    for (int i = 0; i < 32; i++) src_rev[i] = src[31-i];
    ext  = {(ty == SH_LSL) ? src_rev : src, 1'b0};
    fill = '0;
    wide = '0;
    for (int s = 0; s < 5; s++) begin
      unique case (ty)
        SH_ASR:  fill = {32{ext[32]}};
        SH_ROR:  fill = ext[32:1];
        default: fill = '0;
      endcase
      wide = {fill, ext} >> (1 << s);
      if (amt5[s]) ext = wide[32:0];
    end
    for (int i = 0; i < 32; i++) res_rev[i] = ext[32-i];
    result = (ty == SH_LSL) ? res_rev : ext[32:1];
    carry  = ext[0];
  end

endmodule

// File: rtl/shift_stage.sv
// Registered operand-2 shift stage with valid/ready on both sides.
// Define SHIFT_STAGE_SKID_EN for a 2-entry skid buffer with a registered InReady.
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] Src,
  input  logic [1:0]        ShType,
  input  logic              ShByReg,
  input  logic [AMT_W-1:0]  Shamt,
  input  logic              CarryIn,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] ShOut,
  output logic              ShCarry
);

  if (DATA_W != SH_DATA_W || AMT_W != SH_AMT_W) begin : g_width_check
    $error("shift_stage supports only DATA_W=32 and AMT_W=8");
  end

  sh_norm_t    norm;
  sh_result_t  res_d;
  logic [31:0] core_data;
  logic        core_carry;
  logic        accept;

  assign norm   = shift_normalise(ShByReg, sh_type_e'(ShType), Shamt);
  assign accept = InValid & InReady;

  shift_core u_core (
    .kind   (norm.kind),
    .amt5   (norm.amt5),
    .src    (Src),
    .result (core_data),
    .carry  (core_carry)
  );

  always_comb begin
    // NOTE: defaults before the case so every path assigns res_d and no latch is inferred.
    res_d.data  = core_data;
    res_d.carry = core_carry;
    unique case (norm.code)
      SP_PASS:      begin res_d.data = Src;                   res_d.carry = CarryIn;            end
      SP_ZERO_CLSB: begin res_d.data = '0;                    res_d.carry = Src[0];             end
      SP_ZERO_CMSB: begin res_d.data = '0;                    res_d.carry = Src[SH_DATA_W-1];   end
      SP_ZERO_C0:   begin res_d.data = '0;                    res_d.carry = 1'b0;               end
      SP_SIGN:      begin res_d.data = {SH_DATA_W{Src[SH_DATA_W-1]}};
                                                              res_d.carry = Src[SH_DATA_W-1];   end
      SP_RRX:       begin res_d.data = {CarryIn, Src[SH_DATA_W-1:1]};
                                                              res_d.carry = Src[0];             end
      SP_ROR32:     begin res_d.data = Src;                   res_d.carry = Src[SH_DATA_W-1];   end
      default:      ;
    endcase
  end

`ifdef SHIFT_STAGE_SKID_EN
  logic       out_valid_d, out_valid_q;
  logic       skid_valid_d, skid_valid_q;
  logic       in_ready_d, in_ready_q;
  sh_result_t out_d, out_q, skid_d, skid_q;

  // The skid entry is always older than any new request, so it drains first.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (!out_valid_q || OutReady) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = res_d;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = res_d;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: data registers are reset too, because ShOut/ShCarry must read 0 out of reset.
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign InReady = in_ready_q;
`else
  logic       out_valid_d, out_valid_q;
  sh_result_t out_d, out_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (InReady) begin
      out_valid_d = accept;
      if (accept) out_d = res_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign InReady = !out_valid_q || OutReady;
`endif

  assign OutValid = out_valid_q;
  assign ShOut    = out_q.data;
  assign ShCarry  = out_q.carry;

endmodule

// File: tb/tb_shift_stage.sv
// Self-checking bench for shift_stage: directed special cases, reset behaviour,
// back-to-back flow control and a randomized run against a behavioural model.
module tb_shift_stage;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] Src = '0;
  logic [1:0]  ShType = '0;
  logic        ShByReg = 1'b0;
  logic [7:0]  Shamt = '0;
  logic        CarryIn = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] ShOut;
  logic        ShCarry;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] src;
    logic [1:0]  t;
    logic        r;
    logic [7:0]  sh;
    logic        ci;
    logic [32:0] exp;
  } vec_t;

  logic [32:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [32:0] held = '0;
  logic        last_acc = 1'b0;
  int          n_acc = 0;
  int          n_out = 0;

  shift_stage dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .InValid  (InValid),
    .InReady  (InReady),
    .Src      (Src),
    .ShType   (ShType),
    .ShByReg  (ShByReg),
    .Shamt    (Shamt),
    .CarryIn  (CarryIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .ShOut    (ShOut),
    .ShCarry  (ShCarry)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural model written directly from the shift rules; returns {result, carry}.
  function automatic logic [32:0] model(input logic [31:0] s, input logic [1:0] t,
                                        input logic r, input logic [7:0] sh, input logic ci);
    int          a;
    logic [63:0] w;
    logic [31:0] o;
    logic        c;
    a = r ? int'(sh) : int'(sh[4:0]);
    if (a == 0) begin
      if (r || t == 2'd0) return {s, ci};
      case (t)
        2'd1:    return {32'h0, s[31]};
        2'd2:    return {{32{s[31]}}, s[31]};
        default: return {ci, s[31:1], s[0]};
      endcase
    end
    case (t)
      2'd0: begin
        if (a < 32) begin w = {32'h0, s} << a; o = w[31:0]; c = w[32]; end
        else if (a == 32) begin o = 0; c = s[0]; end
        else begin o = 0; c = 1'b0; end
      end
      2'd1: begin
        if (a < 32) begin w = {s, 32'h0} >> a; o = w[63:32]; c = w[31]; end
        else if (a == 32) begin o = 0; c = s[31]; end
        else begin o = 0; c = 1'b0; end
      end
      2'd2: begin
        if (a < 32) begin w = $signed({s, 32'h0}) >>> a; o = w[63:32]; c = w[31]; end
        else begin o = {32{s[31]}}; c = s[31]; end
      end
      default: begin
        if (a % 32 == 0) begin o = s; c = s[31]; end
        else begin w = {s, s} >> (a % 32); o = w[31:0]; c = o[31]; end
      end
    endcase
    return {o, c};
  endfunction

  task automatic set_req(input logic [31:0] s, input logic [1:0] t, input logic r,
                         input logic [7:0] sh, input logic ci);
    Src = s; ShType = t; ShByReg = r; Shamt = sh; CarryIn = ci;
  endtask

  task automatic rand_req();
    logic [7:0] edge_amts[6];
    edge_amts = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64};
    Src     = $urandom();
    ShType  = 2'($urandom_range(0, 3));
    ShByReg = 1'($urandom_range(0, 1));
    CarryIn = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) Shamt = edge_amts[$urandom_range(0, 5)];
    else Shamt = 8'($urandom_range(0, 255));
  endtask

  // One request through an otherwise idle stage; lat counts negedges from accept to OutValid.
  task automatic run_one(input vec_t v, output logic [32:0] got, output bit ok, output int lat);
    bit acc;
    ok = 1'b0; got = '0; lat = 0; acc = 1'b0;
    set_req(v.src, v.t, v.r, v.sh, v.ci);
    OutReady = 1'b1;
    InValid  = 1'b1;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge CLK);
      acc = InValid && InReady;
      @(posedge CLK); #1;
    end
    InValid = 1'b0;
    if (!acc) return;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      if (OutValid) begin
        got = {ShOut, ShCarry}; ok = 1'b1; lat = i;
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  // One clock of scoreboarding: flow-control checks, output compare, input capture.
  task automatic sb_cycle();
    logic [32:0] e;
`ifdef SHIFT_STAGE_SKID_EN
    logic ir0;
`endif
    @(negedge CLK);
`ifdef SHIFT_STAGE_SKID_EN
    ir0 = InReady;
    OutReady = ~OutReady; #1;
    checks++;
    if (InReady !== ir0)
      $display("FAIL inready_comb: InReady=%b moved to %b when OutReady toggled", ir0, InReady);
    OutReady = ~OutReady; #1;
`else
    checks++;
    if (InReady !== (!OutValid || OutReady))
      $display("FAIL inready_eq: InReady=%b OutValid=%b OutReady=%b", InReady, OutValid, OutReady);
`endif
    if (hold_pend) begin
      checks++;
      if (!OutValid || {ShOut, ShCarry} !== held) begin
        errors++;
        $display("FAIL hold_stable: OutValid=%b got=%h expected=%h", OutValid, {ShOut, ShCarry}, held);
      end
    end
    if (OutValid && OutReady) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got=%h with nothing outstanding", {ShOut, ShCarry});
      end else begin
        e = exp_q.pop_front();
        if ({ShOut, ShCarry} !== e) begin
          errors++;
          $display("FAIL result: got out=%h c=%b expected out=%h c=%b", ShOut, ShCarry, e[32:1], e[0]);
        end
      end
    end
    hold_pend = OutValid && !OutReady;
    held      = {ShOut, ShCarry};
    last_acc  = InValid && InReady;
    if (last_acc) begin
      exp_q.push_back(model(Src, ShType, ShByReg, Shamt, CarryIn));
      n_acc++;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    vec_t        v;
    logic [32:0] got;
    bit          ok;
    int          lat;
    #1;
    checks++;
    if (OutValid !== 1'b0 || ShOut !== 32'h0 || ShCarry !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: OutValid=%b ShOut=%h ShCarry=%b expected 0/0/0", OutValid, ShOut, ShCarry);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inready: InReady=%b expected 1", InReady);
    end
    @(posedge CLK); #1;
    set_req(32'h0000_1234, 2'd0, 1'b0, 8'd4, 1'b0);
    OutReady = 1'b0;
    InValid  = 1'b1;
    @(posedge CLK); #1;
    InValid = 1'b0;
    @(negedge CLK);
    checks++;
    if (OutValid !== 1'b1 || ShOut !== 32'h0001_2340) begin
      errors++;
      $display("FAIL pre_reset_out: OutValid=%b ShOut=%h expected 1/00012340", OutValid, ShOut);
    end
    #1 RESET = 1'b1;
    #1;
    checks++;
    if (OutValid !== 1'b0 || ShOut !== 32'h0 || ShCarry !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: OutValid=%b ShOut=%h ShCarry=%b expected 0/0/0", OutValid, ShOut, ShCarry);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: OutValid=%b expected 0 after reset", OutValid);
    end
    @(posedge CLK); #1;
    v = '{32'h0000_00F0, 2'd1, 1'b0, 8'd4, 1'b0, {32'h0000_000F, 1'b0}};
    run_one(v, got, ok, lat);
    checks++;
    if (!ok || got !== v.exp || lat != 1) begin
      errors++;
      $display("FAIL post_reset_req: ok=%b got=%h lat=%0d expected %h lat=1", ok, got, lat, v.exp);
    end
  endtask

  task automatic test_imm_special();
    vec_t        v[6];
    logic [32:0] got;
    bit          ok;
    int          lat;
    v[0] = '{32'h8000_0001, 2'd2, 1'b0, 8'd0,   1'b0, {32'hFFFF_FFFF, 1'b1}};
    v[1] = '{32'h0000_0003, 2'd3, 1'b0, 8'd0,   1'b1, {32'h8000_0001, 1'b1}};
    v[2] = '{32'h8000_0000, 2'd1, 1'b0, 8'd0,   1'b0, {32'h0000_0000, 1'b1}};
    v[3] = '{32'h0000_005A, 2'd0, 1'b0, 8'd0,   1'b1, {32'h0000_005A, 1'b1}};
    v[4] = '{32'hF000_000F, 2'd0, 1'b0, 8'hE4,  1'b0, {32'h0000_00F0, 1'b1}};
    v[5] = '{32'h8000_0010, 2'd2, 1'b0, 8'd4,   1'b1, {32'hF800_0001, 1'b0}};
    foreach (v[i]) begin
      run_one(v[i], got, ok, lat);
      checks++;
      if (!ok || got !== v[i].exp || lat != 1) begin
        errors++;
        $display("FAIL imm_case%0d: ok=%b got=%h lat=%0d expected %h", i, ok, got, lat, v[i].exp);
      end
    end
  endtask

  task automatic test_reg_special();
    vec_t        v[8];
    logic [32:0] got;
    bit          ok;
    int          lat;
    v[0] = '{32'h0000_0001, 2'd0, 1'b1, 8'd32,  1'b0, {32'h0000_0000, 1'b1}};
    v[1] = '{32'h0000_0001, 2'd0, 1'b1, 8'd33,  1'b1, {32'h0000_0000, 1'b0}};
    v[2] = '{32'h0000_0001, 2'd0, 1'b1, 8'd0,   1'b1, {32'h0000_0001, 1'b1}};
    v[3] = '{32'h8000_0000, 2'd3, 1'b1, 8'd64,  1'b0, {32'h8000_0000, 1'b1}};
    v[4] = '{32'h0000_00F1, 2'd3, 1'b1, 8'd4,   1'b1, {32'h1000_000F, 1'b0}};
    v[5] = '{32'h8000_0000, 2'd1, 1'b1, 8'd32,  1'b0, {32'h0000_0000, 1'b1}};
    v[6] = '{32'h7FFF_FFFF, 2'd2, 1'b1, 8'd200, 1'b1, {32'h0000_0000, 1'b0}};
    v[7] = '{32'h0000_0003, 2'd1, 1'b1, 8'd1,   1'b0, {32'h0000_0001, 1'b1}};
    foreach (v[i]) begin
      run_one(v[i], got, ok, lat);
      checks++;
      if (!ok || got !== v[i].exp || lat != 1) begin
        errors++;
        $display("FAIL reg_case%0d: ok=%b got=%h lat=%0d expected %h", i, ok, got, lat, v[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    exp_q.delete();
    hold_pend = 1'b0;
    n_out = 0; sent = 0;
    OutReady = 1'b1;
    rand_req();
    InValid = 1'b1;
    for (int cyc = 0; cyc < 80 && n_out < 8; cyc++) begin
      sb_cycle();
      if (last_acc) begin
        sent++;
        if (sent < 8) rand_req();
        else InValid = 1'b0;
      end
      OutReady = ~OutReady;
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    repeat (4) sb_cycle();
    checks++;
    if (n_out != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: outputs=%0d outstanding=%0d expected 8/0", n_out, exp_q.size());
    end
  endtask

  task automatic test_random();
    int cyc;
    exp_q.delete();
    hold_pend = 1'b0;
    last_acc  = 1'b0;
    n_acc = 0; n_out = 0; cyc = 0;
    InValid = 1'b0;
    while (n_acc < 10000 && cyc < 60000) begin
      if (!InValid || last_acc) begin
        rand_req();
        InValid = ($urandom_range(0, 99) < 75);
      end
      OutReady = ($urandom_range(0, 99) < 70);
      sb_cycle();
      cyc++;
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) sb_cycle();
    checks++;
    if (n_acc < 10000 || exp_q.size() != 0 || n_out != n_acc) begin
      errors++;
      $display("FAIL random_drain: accepted=%0d delivered=%0d outstanding=%0d", n_acc, n_out, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_imm_special();
    test_reg_special();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
